// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the regfile_sb register file: default sizes,
// the hardwired-zero register address and the register address type.
package regfile_sb_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int NREGS_DEF  = 32;
  localparam int ADDR_W_DEF = 5;

  // Register 0 always reads as zero and is never written or tracked.
  localparam int ZERO_ADDR = 0;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Bundle of the read, writeback and issue signals between the pipeline
// (decode and writeback stages) and the register file.
interface regfile_sb_if #(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5
);

  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [WIDTH-1:0]  rs_data;
  logic [WIDTH-1:0]  rt_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_rd;
  logic              stall;
  logic [NREGS-1:0]  busy_mask;

  // Pipeline side: drives addresses, writeback and issue requests.
  modport master (
    output rs_addr, rt_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd,
    input  rs_data, rt_data, stall, busy_mask
  );

  // Register file side.
  modport slave (
    input  rs_addr, rt_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd,
    output rs_data, rt_data, stall, busy_mask
  );

endinterface

// File: rtl/regfile_sb_cell.sv
// Enable/reset register cell: one architectural register with an
// asynchronous active-high clear and a load enable.
module regfile_sb_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load d when enabled; clear immediately on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      // NOTE: sequential state is assigned with <= so every flop samples
      // pre-edge values regardless of block ordering.
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_sb_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an in-flight writer and
// produces the decode stall for RAW (rs/rt) and WAW (rd) hazards.
module reg_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              stall,
  output logic [NREGS-1:0]  busy_mask
);

  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_ADDR);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_n;
  logic             hz_rs;
  logic             hz_rt;
  logic             hz_rd;
  logic             accept;

  // Hazard terms and stall; with bypass, a same-cycle writeback to the
  // pending register resolves the hazard since its data is forwarded.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    hz_rs = 1'b0;
    hz_rt = 1'b0;
    hz_rd = 1'b0;
    if (rs_addr != ZERO) begin
      hz_rs = busy[rs_addr] && !(BYPASS != 0 && wr_en && wr_addr == rs_addr);
    end
    if (rt_addr != ZERO) begin
      hz_rt = busy[rt_addr] && !(BYPASS != 0 && wr_en && wr_addr == rt_addr);
    end
    if (issue_rd != ZERO) begin
      hz_rd = busy[issue_rd] && !(BYPASS != 0 && wr_en && wr_addr == issue_rd);
    end
    stall  = issue_en && (hz_rs || hz_rt || hz_rd);
    accept = issue_en && !stall && (issue_rd != ZERO);
  end

  // Next busy bits: writeback clears, accepted issue sets; set applied last
  // so a new in-flight writer keeps ownership.
  always_comb begin
    busy_n = busy;
    if (wr_en && wr_addr != ZERO) begin
      busy_n[wr_addr] = 1'b0;
    end
    if (accept) begin
      busy_n[issue_rd] = 1'b1;
    end
    busy_n[ZERO_ADDR] = 1'b0;
  end

  // Busy bit register, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      busy <= busy_n;
    end
  end

  assign busy_mask = busy;

endmodule

// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port,
// hardwired zero register, optional write-to-read forwarding and a
// busy-bit scoreboard that stalls decode on pending operands.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BYPASS = 1
) (
  input  logic         clk,
  input  logic         reset,
  regfile_sb_if.slave  bus
);

  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_ADDR);

  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:1] we;
  logic             cell_rst;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;

  // The register cells clear on an active-high reset.
  assign cell_rst = ~reset;

  // One-hot write decoder; register 0 has no cell and is never enabled.
  always_comb begin
    for (int i = 1; i < NREGS; i++) begin
      we[i] = bus.wr_en && (bus.wr_addr == ADDR_W'(i));
    end
  end

  assign regs[ZERO_ADDR] = '0;

  // NOTE: the data array is reset on purpose: every architectural register
  // must read zero right after reset, so each cell carries a clear.
  for (genvar g = 1; g < NREGS; g++) begin : g_cell
    regfile_sb_cell #(.WIDTH(WIDTH)) u_cell (
      .clk (clk),
      .rst (cell_rst),
      .en  (we[g]),
      .d   (bus.wr_data),
      .q   (regs[g])
    );
  end

  // Read ports with optional forwarding of the same-cycle writeback.
  always_comb begin
    rs_val = regs[bus.rs_addr];
    rt_val = regs[bus.rt_addr];
    if (BYPASS != 0 && bus.wr_en && bus.wr_addr != ZERO) begin
      if (bus.wr_addr == bus.rs_addr) rs_val = bus.wr_data;
      if (bus.wr_addr == bus.rt_addr) rt_val = bus.wr_data;
    end
  end

  assign bus.rs_data = rs_val;
  assign bus.rt_data = rt_val;

  reg_scoreboard #(
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .rs_addr   (bus.rs_addr),
    .rt_addr   (bus.rt_addr),
    .wr_en     (bus.wr_en),
    .wr_addr   (bus.wr_addr),
    .issue_en  (bus.issue_en),
    .issue_rd  (bus.issue_rd),
    .stall     (bus.stall),
    .busy_mask (bus.busy_mask)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a bypassing and a non-bypassing instance driven
// with the same directed stimulus, compared every cycle to a behavioural
// model, plus literal expectations at the key points.
module tb_regfile_sb;
  import regfile_sb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  reg_addr_t   rs_addr, rt_addr, wr_addr, issue_rd;
  logic        wr_en, issue_en;
  logic [31:0] wr_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.WIDTH(32), .NREGS(32), .ADDR_W(5)) bus_b1 ();
  regfile_sb_if #(.WIDTH(32), .NREGS(32), .ADDR_W(5)) bus_b0 ();

  assign bus_b1.rs_addr  = rs_addr;   assign bus_b0.rs_addr  = rs_addr;
  assign bus_b1.rt_addr  = rt_addr;   assign bus_b0.rt_addr  = rt_addr;
  assign bus_b1.wr_en    = wr_en;     assign bus_b0.wr_en    = wr_en;
  assign bus_b1.wr_addr  = wr_addr;   assign bus_b0.wr_addr  = wr_addr;
  assign bus_b1.wr_data  = wr_data;   assign bus_b0.wr_data  = wr_data;
  assign bus_b1.issue_en = issue_en;  assign bus_b0.issue_en = issue_en;
  assign bus_b1.issue_rd = issue_rd;  assign bus_b0.issue_rd = issue_rd;

  regfile_sb #(.BYPASS(1)) dut    (.clk(clk), .reset(reset), .bus(bus_b1));
  regfile_sb #(.BYPASS(0)) dut_nb (.clk(clk), .reset(reset), .bus(bus_b0));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (index 1: bypass, 0: no bypass)
  logic [31:0] m_regs [2][32];
  logic [31:0] m_busy [2];

  function automatic logic [31:0] m_read(int b, reg_addr_t a);
    if (a == 0) return 32'h0;
    if (b == 1 && wr_en && wr_addr == a) return wr_data;
    return m_regs[b][a];
  endfunction

  function automatic logic m_hz(int b, reg_addr_t a);
    return (a != 0) && m_busy[b][a] && !(b == 1 && wr_en && wr_addr == a);
  endfunction

  function automatic logic m_stall(int b);
    return issue_en && (m_hz(b, rs_addr) || m_hz(b, rt_addr) || m_hz(b, issue_rd));
  endfunction

  function automatic logic [31:0] m_next_busy(int b);
    logic [31:0] nb;
    nb = m_busy[b];
    if (wr_en && wr_addr != 0) nb[wr_addr] = 1'b0;
    if (issue_en && !m_stall(b) && issue_rd != 0) nb[issue_rd] = 1'b1;
    return nb;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        m_busy[b] <= 32'h0;
        for (int i = 0; i < 32; i++) m_regs[b][i] <= 32'h0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        m_busy[b] <= m_next_busy(b);
        if (wr_en && wr_addr != 0) m_regs[b][wr_addr] <= wr_data;
      end
    end
  end

  // ---------------- per-cycle compare, away from the active edge
  always @(negedge clk) begin
    check("cyc_b1_rs",    bus_b1.rs_data,   m_read(1, rs_addr));
    check("cyc_b1_rt",    bus_b1.rt_data,   m_read(1, rt_addr));
    check("cyc_b1_stall", 32'(bus_b1.stall), 32'(m_stall(1)));
    check("cyc_b1_busy",  bus_b1.busy_mask, m_busy[1]);
    check("cyc_b0_rs",    bus_b0.rs_data,   m_read(0, rs_addr));
    check("cyc_b0_rt",    bus_b0.rt_data,   m_read(0, rt_addr));
    check("cyc_b0_stall", 32'(bus_b0.stall), 32'(m_stall(0)));
    check("cyc_b0_busy",  bus_b0.busy_mask, m_busy[0]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus with literal expectations
  initial begin
    reset = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0;
    issue_en = 0; issue_rd = 0; rs_addr = 0; rt_addr = 0;
    #2 reset = 1'b0;
    #1;
    check("init_rs",    bus_b1.rs_data, 32'h0);
    check("init_busy",  bus_b1.busy_mask, 32'h0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Reset then read
    wr_en = 1; wr_addr = 5; wr_data = 32'd7;
    tick();
    wr_addr = 31; wr_data = 32'd9;
    tick();
    wr_en = 0; rs_addr = 5; rt_addr = 31;
    #1;
    check("pre_reset_rs5",  bus_b1.rs_data, 32'd7);
    check("pre_reset_rt31", bus_b1.rt_data, 32'd9);
    #1 reset = 1'b0;
    #1;
    check("async_reset_rs5",   bus_b1.rs_data, 32'h0);
    check("async_reset_rt31",  bus_b1.rt_data, 32'h0);
    check("async_reset_busy",  bus_b1.busy_mask, 32'h0);
    check("async_reset_stall", 32'(bus_b1.stall), 32'h0);
    reset = 1'b1;
    tick();

    // Basic write and read, write to $0 ignored
    wr_en = 1; wr_addr = 3; wr_data = 32'd10;
    tick();
    wr_addr = 4; wr_data = 32'd88;
    tick();
    wr_addr = 0; wr_data = 32'd89;
    tick();
    wr_en = 0; rs_addr = 3; rt_addr = 4;
    #1;
    check("read_r3", bus_b1.rs_data, 32'd10);
    check("read_r4", bus_b1.rt_data, 32'd88);
    check("read_r4_nb", bus_b0.rt_data, 32'd88);
    rs_addr = 0;
    #1;
    check("read_r0", bus_b1.rs_data, 32'h0);
    tick();

    // Bypass
    wr_en = 1; wr_addr = 7; wr_data = 32'hDEADBEEF; rs_addr = 7;
    #1;
    check("bypass_rs",    bus_b1.rs_data, 32'hDEADBEEF);
    check("no_bypass_rs", bus_b0.rs_data, 32'h0);
    tick();
    wr_en = 0;
    #1;
    check("no_bypass_after_edge", bus_b0.rs_data, 32'hDEADBEEF);
    tick();

    // RAW stall
    issue_en = 1; issue_rd = 9; rs_addr = 0; rt_addr = 0;
    #1;
    check("issue9_accept", 32'(bus_b1.stall), 32'h0);
    tick();
    issue_rd = 10; rs_addr = 9;
    #1;
    check("raw_stall",  32'(bus_b1.stall), 32'h1);
    check("raw_busy9",  bus_b1.busy_mask, 32'h0000_0200);
    tick();
    check("raw_stall_held", 32'(bus_b1.stall), 32'h1);
    wr_en = 1; wr_addr = 9; wr_data = 32'h0000_1234;
    #1;
    check("wb_cycle_stall",    32'(bus_b1.stall), 32'h0);
    check("wb_cycle_rs",       bus_b1.rs_data, 32'h0000_1234);
    check("wb_cycle_stall_nb", 32'(bus_b0.stall), 32'h1);
    tick();
    wr_en = 0; issue_en = 0;
    #1;
    check("after_wb_busy",    bus_b1.busy_mask, 32'h0000_0400);
    check("after_wb_busy_nb", bus_b0.busy_mask, 32'h0);
    check("after_wb_rs_nb",   bus_b0.rs_data, 32'h0000_1234);
    wr_en = 1; wr_addr = 10; wr_data = 32'd5;
    tick();
    wr_en = 0;

    // WAW and set/clear collision
    issue_en = 1; issue_rd = 12; rs_addr = 0; rt_addr = 0;
    tick();
    wr_en = 1; wr_addr = 12; wr_data = 32'h55;
    #1;
    check("waw_collide_stall",    32'(bus_b1.stall), 32'h0);
    check("waw_collide_stall_nb", 32'(bus_b0.stall), 32'h1);
    tick();
    check("set_wins_busy",   bus_b1.busy_mask, 32'h0000_1000);
    check("waw_nb_cleared",  bus_b0.busy_mask, 32'h0);
    wr_en = 0; issue_rd = 0;
    #1;
    check("issue_rd0_stall", 32'(bus_b1.stall), 32'h0);
    tick();
    check("issue_rd0_busy", bus_b1.busy_mask, 32'h0000_1000);
    issue_en = 0; wr_en = 1; wr_addr = 12; wr_data = 32'h66;
    tick();
    wr_en = 0;
    #1;
    check("clear12_busy", bus_b1.busy_mask, 32'h0);
    tick();

    // Reset mid-operation, then a write pending at deassertion
    wr_en = 1; wr_addr = 5; wr_data = 32'd44; issue_en = 1; issue_rd = 5;
    tick();
    wr_en = 0; issue_en = 0; rs_addr = 5;
    #1;
    check("mid_rs5",   bus_b1.rs_data, 32'd44);
    check("mid_busy5", bus_b1.busy_mask, 32'h0000_0020);
    reset = 1'b0;
    #1;
    check("mid_reset_busy", bus_b1.busy_mask, 32'h0);
    check("mid_reset_rs5",  bus_b1.rs_data, 32'h0);
    wr_en = 1; wr_addr = 5; wr_data = 32'd77;
    #1 reset = 1'b1;
    #1;
    check("pending_wr_not_yet", bus_b0.rs_data, 32'h0);
    tick();
    wr_en = 0;
    #1;
    check("pending_wr_done",    bus_b1.rs_data, 32'd77);
    check("pending_wr_done_nb", bus_b0.rs_data, 32'd77);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
